// File: rtl/vr_rr_arbiter.sv
// Round-robin valid/ready arbiter: N sources share one registered output stage.
// A source keeps the grant for up to MAX_BURST consecutive beats while it stays valid.
module vr_rr_arbiter #(
    parameter int N         = 4,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4,
    parameter int IDW       = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_valid,
    input  logic [N*DW-1:0] in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [IDW-1:0]  out_id,
    input  logic            out_ready
);

    localparam int             BW     = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]  MAX_B  = BW'(MAX_BURST);
    localparam logic [BW-1:0]  ONE_B  = BW'(1);
    localparam logic [IDW-1:0] LAST_I = IDW'(N - 1);

    logic [IDW-1:0] ptr;
    logic [BW-1:0]  burst_cnt;
    logic           sticky;
    logic           grant_vld;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] scan_idx;
    logic [DW-1:0]  grant_data;
    logic           slot_free;
    logic           accept;

    assign slot_free = ~out_valid | out_ready;
    assign sticky    = in_valid[ptr] && (burst_cnt != '0) && (burst_cnt < MAX_B);
    assign accept    = grant_vld & slot_free & ~rst;

    // Scan starts just past the last-accepted index and ends on it, so a lone
    // requester at its burst limit is still re-granted.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr;
        scan_idx  = '0;
        if (sticky) begin
            grant_vld = 1'b1;
        end else begin
            for (int k = 1; k <= N; k++) begin
                scan_idx = IDW'((int'(ptr) + k) % N);
                if (!grant_vld && in_valid[scan_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == IDW'(i)) begin
                grant_data  = in_data[i*DW +: DW];
                in_ready[i] = accept;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            ptr       <= LAST_I;
            burst_cnt <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_id    <= grant_idx;
            ptr       <= grant_idx;
            burst_cnt <= (grant_idx == ptr && burst_cnt < MAX_B) ? burst_cnt + ONE_B : ONE_B;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Directed bench for vr_rr_arbiter (N=4, MAX_BURST=4): reset, streaming,
// fairness, backpressure, drop-out and mid-stream reset.
module tb_vr_rr_arbiter;

    localparam int N         = 4;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;
    localparam int IDW       = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [IDW-1:0]  out_id;
    logic            out_ready;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int seq [N];
    int b;
    int e;
    logic [31:0] last_data;
    int          last_id;

    logic [N-1:0] d_valid [7] = '{4'b1100, 4'b1100, 4'b1000, 4'b1100, 4'b1100, 4'b1100, 4'b1100};
    int           d_id    [7] = '{2, 2, 3, 3, 3, 3, 2};

    vr_rr_arbiter #(.N(N), .DW(DW), .MAX_BURST(MAX_BURST), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_seq();
        for (int i = 0; i < N; i++) seq[i] = 0;
    endtask

    task automatic set_seq_data();
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 32'((i << 8) | seq[i]);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = '1;
        out_ready = 1'b1;
        clr_seq();
        set_seq_data();

        // reset held 3 cycles with all requesters valid
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_in_ready", 32'(in_ready), 32'h0);
            chk("rst_out_valid", 32'(out_valid), 32'h0);
        end
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_id", 32'(out_id), 32'h0);

        // all requesters valid: 4-beat bursts in order 0,1,2,3,0
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            e = (k / MAX_BURST) % N;
            set_seq_data();
            #1;
            chk("all_in_ready", 32'(in_ready), 32'(1 << e));
            tick();
            chk("all_out_valid", 32'(out_valid), 32'h1);
            chk("all_out_id", 32'(out_id), 32'(e));
            chk("all_out_data", out_data, 32'((e << 8) | seq[e]));
            seq[e]++;
        end

        // single requester streams 16 beats with no bubble at the burst limit
        reset_dut();
        in_valid = 4'b0010;
        for (int k = 0; k < 16; k++) begin
            in_data[1*DW +: DW] = 32'h100 + 32'(k);
            #1;
            chk("one_in_ready", 32'(in_ready), 32'h2);
            tick();
            chk("one_out_valid", 32'(out_valid), 32'h1);
            chk("one_out_id", 32'(out_id), 32'h1);
            chk("one_out_data", out_data, 32'h100 + 32'(k));
        end
        in_valid = '0;
        #1;
        chk("one_idle_ready", 32'(in_ready), 32'h0);
        tick();
        chk("one_drain_valid", 32'(out_valid), 32'h0);
        chk("one_drain_data", out_data, 32'h10F);
        chk("one_drain_id", 32'(out_id), 32'h1);

        // backpressure: out_ready pattern 1,0,0,1 repeating
        reset_dut();
        in_valid = '1;
        clr_seq();
        b = 0;
        for (int c = 0; c < 24; c++) begin
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            e = (b / MAX_BURST) % N;
            set_seq_data();
            #1;
            chk("bp_in_ready", 32'(in_ready), out_ready ? 32'(1 << e) : 32'h0);
            tick();
            chk("bp_out_valid", 32'(out_valid), 32'h1);
            if (out_ready) begin
                chk("bp_new_id", 32'(out_id), 32'(e));
                chk("bp_new_data", out_data, 32'((e << 8) | seq[e]));
                last_id   = e;
                last_data = 32'((e << 8) | seq[e]);
                seq[e]++;
                b++;
            end else begin
                chk("bp_hold_id", 32'(out_id), 32'(last_id));
                chk("bp_hold_data", out_data, last_data);
            end
        end
        chk("bp_beats_id0", 32'(seq[0]), 32'd4);
        chk("bp_beats_id1", 32'(seq[1]), 32'd4);
        chk("bp_beats_id2", 32'(seq[2]), 32'd4);

        // requester 2 drops out after 2 beats; 3 then gets a full fresh burst
        reset_dut();
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            in_valid = d_valid[c];
            for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 32'hD000 | 32'(i << 8) | 32'(c);
            #1;
            chk("drop_in_ready", 32'(in_ready), 32'(1 << d_id[c]));
            tick();
            chk("drop_out_valid", 32'(out_valid), 32'h1);
            chk("drop_out_id", 32'(out_id), 32'(d_id[c]));
            chk("drop_out_data", out_data, 32'hD000 | 32'(d_id[c] << 8) | 32'(c));
        end

        // reset while a beat is stalled on the output
        out_ready = 1'b0;
        in_valid  = '1;
        #1;
        chk("mrst_stall_ready", 32'(in_ready), 32'h0);
        tick();
        chk("mrst_stall_valid", 32'(out_valid), 32'h1);
        chk("mrst_stall_id", 32'(out_id), 32'h2);
        rst = 1'b1;
        #1;
        chk("mrst_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk("mrst_out_valid", 32'(out_valid), 32'h0);
        chk("mrst_out_data", out_data, 32'h0);
        chk("mrst_out_id", 32'(out_id), 32'h0);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mrst_first_ready", 32'(in_ready), 32'h1);
        tick();
        chk("mrst_first_valid", 32'(out_valid), 32'h1);
        chk("mrst_first_id", 32'(out_id), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
